serial_frame_responder: RTL and testbench
=========================================

Name: serial_frame_responder

Overview:
- Responder end of the two-wire serial frame link (serialClock/serialData).
- Oversamples an incoming frame of WORDS words of WIDTH bits each in its local clock domain and presents each word as it completes.
- After a complete frame, it transmits a one-word reply frame carrying the mod-2^WIDTH sum of the received words. The reply uses the same two-wire protocol on its own output pair, so the initiator can confirm delivery.

Parameters:
- WIDTH, 8, bits per word.
- WORDS, 2, words per incoming frame (≥1).
- HALF, 4, local clock cycles per half-period of the reply serial clock (≥1).
- TIMEOUT, 64, local cycles with no rising serialClock edge mid-frame before the frame is aborted.

Ports:
- clock  in  1  local clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- serialClock  in  1  incoming serial clock, asynchronous to clock.
- serialData  in  1  incoming serial data; valid at serialClock rising edge.
- word  out  WIDTH  last completed received word.
- index  out  $clog2(WORDS) (min 1)  position of word within the frame.
- wordValid  out  1  one-cycle pulse when word/index update.
- frameReady  out  1  one-cycle pulse when the last word of a frame completes.
- abort  out  1  one-cycle pulse on mid-frame timeout.
- replyClock  out  1  outgoing serial clock.
- replyData  out  1  outgoing serial data, MSB first.
- busy  out  1  high while a reply is being sent.

Behaviour:
- Reset values: word=0, index=0, wordValid=0, frameReady=0, abort=0, replyClock=0, replyData=0, busy=0. The state machine returns to IDLE, all counters clear and the checksum clears.
- Input sync:
  - serialClock and serialData each pass through 2 flops.
  - A rising edge is detected as sync=1 and previous=0.
  - Data is sampled from the synchronized data flop in the edge cycle.
  - Initiator must hold serialData stable ≥3 local cycles either side of its clock edge.
- Bit assembly:
  - MSB first; shift register shifts left on each edge.
  - On the WIDTH-th bit of a word, the cycle after the edge: word=assembled value, index=word count, wordValid=1, checksum+=word (truncate to WIDTH).
  - Latency: word appears 1 cycle after the detected edge, i.e. 4 clock cycles after the raw edge.
- States:
  - IDLE: first edge -> RECEIVE (that edge is bit 0).
  - RECEIVE:
    - After WORDS*WIDTH edges: frameReady pulses with the last wordValid -> SETUP.
    - Idle counter reaches TIMEOUT with no edge: abort=1, discard partial word and checksum, clear counters -> IDLE. No word or reply is produced for a partial frame.
  - SETUP: replyData=checksum MSB, replyClock=0, busy=1. Hold HALF cycles -> HIGH.
  - HIGH: replyClock=1, hold HALF cycles -> LOW.
  - LOW: replyClock=0, hold HALF cycles. Then either next bit -> HIGH with replyData updated on entry to LOW's final cycle, or after WIDTH bits -> IDLE with busy=0 and replyData=0.
  - Each reply bit is 2*HALF cycles; the reply frame is WIDTH*2*HALF + HALF cycles long.
- Incoming edges while busy are ignored and do not start a frame. The synchronizer keeps running, so the first edge after busy falls is detected normally.
- Checksum clears on entry to RECEIVE.
- Reset asserted mid-reply: replyClock=0, replyData=0, busy=0 on the next cycle, and no partial bits resume.
- Reset wins over all simultaneous events.
- Back-to-back frames are accepted immediately after the reply completes.

Decomposition:
- Package serial_frame_pkg holds:
  - the state enum (IDLE, RECEIVE, SETUP, HIGH, LOW);
  - the default WIDTH, WORDS, HALF and TIMEOUT constants;
  - a checksum-add function (WIDTH-bit wrap).
- One natural sub-module: serial_edge_sync (2-flop synchronizer on clock and data plus rising-edge detect; outputs edge pulse and sampled bit).

Test Plan:
- Frame 0x76,0xA5 (WIDTH=8, WORDS=2):
  - wordValid with word=0x76/index=0, then 0xA5/index=1;
  - frameReady with the second word;
  - replyData bits 00011011 (0x1B) sampled on replyClock rises.
  - busy is high for 8*8+4=68 cycles.
- Send 5 bits then stall 64 cycles -> abort pulses once, no wordValid, no reply. Then frame 0x01,0x02 -> reply 0x03.
- Send edges during the reply -> ignored, reply still 0x1B. Then frame 0xFF,0x01 -> reply 0x00 (wrap).
- Assert reset at reply bit 3 -> next cycle replyClock=0, replyData=0, busy=0. Then a new frame 0x10,0x20 -> reply 0x30.
- Data toggling away from serialClock edges, stable ≥3 cycles around them -> words unaffected; 16 random frames match the checksum model.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame responder.
//   - state encoding of the receive / reply controller
//   - default geometry (WIDTH, WORDS, HALF, TIMEOUT)
//   - checksum_add: modular add that wraps at the given word width
package serial_frame_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_WORDS   = 2;
   localparam int DEF_HALF    = 4;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RECEIVE = 3'd1,
      SETUP   = 3'd2,
      HIGH    = 3'd3,
      LOW     = 3'd4
   } state_e;

   function automatic logic [31:0] checksum_add(input logic [31:0] acc,
                                                input logic [31:0] value,
                                                input int          width);
      logic [31:0] mask;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (acc + value) & mask;
   endfunction

endpackage

// File: rtl/serial_frame_responder_if.sv
// Link-side signal bundle of the serial frame responder.
//   master : the initiator / observer side (drives serialClock, serialData)
//   slave  : the responder (drives received words, status pulses, reply pair)
interface serial_frame_responder_if
   import serial_frame_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int WORDS = DEF_WORDS
);
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic             serialClock;
   logic             serialData;
   logic [WIDTH-1:0] word;
   logic [IDX_W-1:0] index;
   logic             wordValid;
   logic             frameReady;
   logic             abort;
   logic             replyClock;
   logic             replyData;
   logic             busy;

   modport master (
      output serialClock, serialData,
      input  word, index, wordValid, frameReady, abort, replyClock, replyData, busy
   );

   modport slave (
      input  serialClock, serialData,
      output word, index, wordValid, frameReady, abort, replyClock, replyData, busy
   );

endinterface

// File: rtl/serial_edge_sync.sv
// Brings the asynchronous serial clock/data pair into the local domain.
//   clock, reset  : local clock, synchronous active-high reset
//   sclk, sdata   : raw serial clock and data
//   edge_pulse    : one-cycle pulse per rising edge of sclk
//   sample_bit    : synchronized data, aligned with edge_pulse
// edge_pulse is registered, so it lands three local cycles after the raw edge.
module serial_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic sclk,
   input  logic sdata,
   output logic edge_pulse,
   output logic sample_bit
);

   logic clk_s1, clk_s2, clk_prev;
   logic dat_s1, dat_s2;

   always_ff @(posedge clock) begin
      if (reset) begin
         clk_s1     <= 1'b0;
         clk_s2     <= 1'b0;
         clk_prev   <= 1'b0;
         dat_s1     <= 1'b0;
         dat_s2     <= 1'b0;
         edge_pulse <= 1'b0;
         sample_bit <= 1'b0;
      end else begin
         clk_s1     <= sclk;
         clk_s2     <= clk_s1;
         clk_prev   <= clk_s2;
         dat_s1     <= sdata;
         dat_s2     <= dat_s1;
         edge_pulse <= clk_s2 & ~clk_prev;
         sample_bit <= dat_s2;
      end
   end

endmodule

// File: rtl/serial_frame_responder.sv
// Responder end of the two-wire serial frame link.
//   clock, reset : local clock, synchronous active-high reset
//   bus (slave)  : serialClock/serialData in; word/index/wordValid,
//                  frameReady, abort, replyClock/replyData, busy out
// Receives WORDS words of WIDTH bits MSB first, then replies with one word
// holding their wrapped sum on replyClock/replyData.
//
// state   | meaning
// IDLE    | waiting for the first serial edge of a frame
// RECEIVE | shifting in bits, idle timer armed
// SETUP   | reply MSB on replyData, replyClock low, HALF cycles
// HIGH    | replyClock high, HALF cycles
// LOW     | replyClock low, HALF cycles; next bit set in its last cycle
module serial_frame_responder
   import serial_frame_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int WORDS   = DEF_WORDS,
   parameter int HALF    = DEF_HALF,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clock,
   input  logic                    reset,
   serial_frame_responder_if.slave bus
);

   localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int BIT_W  = $clog2(WIDTH + 1);
   localparam int WCNT_W = $clog2(WORDS + 1);
   localparam int TMR_W  = $clog2(HALF + 1);
   localparam int IDL_W  = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE    = 3'(IDLE);
   localparam logic [2:0] S_RECEIVE = 3'(RECEIVE);
   localparam logic [2:0] S_SETUP   = 3'(SETUP);
   localparam logic [2:0] S_HIGH    = 3'(HIGH);
   localparam logic [2:0] S_LOW     = 3'(LOW);

   logic             edge_pulse, sample_bit;
   logic [2:0]       state;
   logic [WIDTH-1:0] shift, checksum, tx_shift;
   logic [BIT_W-1:0] bit_cnt, tx_cnt;
   logic [WCNT_W-1:0] word_cnt;
   logic [IDL_W-1:0] idle_cnt;
   logic [TMR_W-1:0] timer;

   logic [WIDTH-1:0] shift_next, csum_base, csum_next, tx_next;
   logic             accept, word_done, frame_done, last_bit, load_bit;

   serial_edge_sync u_sync (
      .clock      (clock),
      .reset      (reset),
      .sclk       (bus.serialClock),
      .sdata      (bus.serialData),
      .edge_pulse (edge_pulse),
      .sample_bit (sample_bit)
   );

   always_comb begin
      shift_next = WIDTH'({shift, sample_bit});
      // the first edge of a frame starts from a cleared checksum
      csum_base  = (state == S_IDLE) ? '0 : checksum;
      csum_next  = WIDTH'(checksum_add(32'(csum_base), 32'(shift_next), WIDTH));
      accept     = edge_pulse && ((state == S_IDLE) || (state == S_RECEIVE));
      word_done  = (bit_cnt == BIT_W'(WIDTH - 1));
      frame_done = word_done && (word_cnt == WCNT_W'(WORDS - 1));
      tx_next    = tx_shift << 1;
      last_bit   = (tx_cnt == BIT_W'(WIDTH - 1));
      // next reply bit goes out in the final cycle of LOW; with HALF == 1
      // that final cycle is the first one, so it is loaded leaving HIGH
      load_bit   = !last_bit &&
                   (((state == S_HIGH) && (timer == '0) && (HALF == 1)) ||
                    ((state == S_LOW) && (timer == TMR_W'(1))));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         shift          <= '0;
         checksum       <= '0;
         tx_shift       <= '0;
         bit_cnt        <= '0;
         tx_cnt         <= '0;
         word_cnt       <= '0;
         idle_cnt       <= '0;
         timer          <= '0;
         bus.word       <= '0;
         bus.index      <= '0;
         bus.wordValid  <= 1'b0;
         bus.frameReady <= 1'b0;
         bus.abort      <= 1'b0;
         bus.replyClock <= 1'b0;
         bus.replyData  <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         bus.wordValid  <= 1'b0;
         bus.frameReady <= 1'b0;
         bus.abort      <= 1'b0;

         case (state)
            S_IDLE, S_RECEIVE: begin
               if (accept) begin
                  state    <= S_RECEIVE;
                  idle_cnt <= IDL_W'(TIMEOUT - 1);
                  if (word_done) begin
                     shift         <= '0;
                     bit_cnt       <= '0;
                     checksum      <= csum_next;
                     bus.word      <= shift_next;
                     bus.index     <= IDX_W'(word_cnt);
                     bus.wordValid <= 1'b1;
                     if (frame_done) begin
                        state          <= S_SETUP;
                        word_cnt       <= '0;
                        timer          <= TMR_W'(HALF - 1);
                        tx_shift       <= csum_next;
                        tx_cnt         <= '0;
                        bus.frameReady <= 1'b1;
                        bus.replyData  <= csum_next[WIDTH-1];
                        bus.replyClock <= 1'b0;
                        bus.busy       <= 1'b1;
                     end else begin
                        word_cnt <= word_cnt + 1'b1;
                     end
                  end else begin
                     shift    <= shift_next;
                     bit_cnt  <= bit_cnt + 1'b1;
                     checksum <= csum_base;
                  end
               end else if (state == S_RECEIVE) begin
                  if (idle_cnt == '0) begin
                     state     <= S_IDLE;
                     shift     <= '0;
                     bit_cnt   <= '0;
                     word_cnt  <= '0;
                     checksum  <= '0;
                     bus.abort <= 1'b1;
                  end else begin
                     idle_cnt <= idle_cnt - 1'b1;
                  end
               end
            end

            S_SETUP: begin
               if (timer == '0) begin
                  state          <= S_HIGH;
                  timer          <= TMR_W'(HALF - 1);
                  bus.replyClock <= 1'b1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            S_HIGH: begin
               if (timer == '0) begin
                  state          <= S_LOW;
                  timer          <= TMR_W'(HALF - 1);
                  bus.replyClock <= 1'b0;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            S_LOW: begin
               if (timer == '0) begin
                  if (last_bit) begin
                     state         <= S_IDLE;
                     tx_cnt        <= '0;
                     bus.busy      <= 1'b0;
                     bus.replyData <= 1'b0;
                  end else begin
                     state          <= S_HIGH;
                     timer          <= TMR_W'(HALF - 1);
                     tx_cnt         <= tx_cnt + 1'b1;
                     bus.replyClock <= 1'b1;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase

         if (load_bit) begin
            tx_shift      <= tx_next;
            bus.replyData <= tx_next[WIDTH-1];
         end
      end
   end

endmodule

// File: tb/tb_serial_frame_responder.sv
// Self-checking bench for serial_frame_responder (default geometry:
// WIDTH=8, WORDS=2, HALF=4, TIMEOUT=64).
module tb_serial_frame_responder;
   import serial_frame_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   serial_frame_responder_if bus ();
   serial_frame_responder dut (.clock(clock), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- observer: turns DUT activity into transactions
   logic [7:0] word_q[$];
   int         idx_q[$];
   int         lat_q[$];
   logic [7:0] reply_q[$];
   int         busy_q[$];
   int         fr_cnt = 0, fr_ok = 0, ab_cnt = 0, rx_bits = 0, busy_cnt = 0;
   logic [7:0] rx_val = '0;
   logic       prev_rc = 1'b0, prev_busy = 1'b0;

   always @(negedge clock) begin
      if (reset) begin
         rx_bits = 0; rx_val = '0; busy_cnt = 0; prev_rc = 1'b0; prev_busy = 1'b0;
      end else begin
         if (bus.wordValid) begin
            word_q.push_back(bus.word);
            idx_q.push_back(int'(bus.index));
            lat_q.push_back(cyc - rise_cyc);
         end
         if (bus.frameReady) begin
            fr_cnt++;
            if (bus.wordValid && bus.index == 1'b1) fr_ok++;
         end
         if (bus.abort) ab_cnt++;
         if (bus.busy) busy_cnt++;
         if (bus.replyClock && !prev_rc) begin
            rx_val = {rx_val[6:0], bus.replyData};
            rx_bits++;
         end
         if (prev_busy && !bus.busy) begin
            reply_q.push_back(rx_val);
            busy_q.push_back(busy_cnt);
            rx_bits = 0; busy_cnt = 0;
         end
         prev_rc   = bus.replyClock;
         prev_busy = bus.busy;
      end
   end

   // ---------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // data held >=4 cycles either side of the rising edge; optional junk elsewhere
   task automatic send_bit(input logic b, input bit noise);
      bus.serialData = b;
      tick(4);
      bus.serialClock = 1'b1;
      rise_cyc = cyc;
      tick(4);
      if (noise) bus.serialData = 1'($urandom);
      tick(2);
      bus.serialClock = 1'b0;
      tick(2);
      if (noise) bus.serialData = 1'($urandom);
      tick(2);
   endtask

   task automatic send_word(input logic [7:0] w, input bit noise);
      for (int i = 7; i >= 0; i--) send_bit(w[i], noise);
   endtask

   task automatic get_reply(output logic [7:0] r, output bit got);
      got = 1'b0;
      r   = '0;
      for (int i = 0; i < 400 && !got; i++) begin
         tick(1);
         if (reply_q.size() > 0) got = 1'b1;
      end
      if (got) r = reply_q.pop_front();
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp, input bit noise, input bit inject);
      int fr0, ok0;
      logic [7:0] r;
      bit got;
      word_q.delete(); idx_q.delete(); lat_q.delete(); busy_q.delete(); reply_q.delete();
      fr0 = fr_cnt;
      ok0 = fr_ok;
      send_word(a, noise);
      send_word(b, noise);
      if (inject) begin
         for (int i = 0; i < 200 && !bus.busy; i++) tick(1);
         send_bit(1'b1, 1'b0);
         send_bit(1'b0, 1'b0);
         send_bit(1'b1, 1'b0);
      end
      get_reply(r, got);
      check("reply_done", 32'(got), 32'd1);
      if (got) check("reply_value", r, exp);
      check("word_count", word_q.size(), 2);
      if (word_q.size() == 2) begin
         check("word0", word_q[0], a);
         check("index0", idx_q[0], 0);
         check("word1", word_q[1], b);
         check("index1", idx_q[1], 1);
         check("latency0", lat_q[0], 4);
         check("latency1", lat_q[1], 4);
      end
      check("frame_ready", fr_cnt - fr0, 1);
      check("frame_ready_align", fr_ok - ok0, 1);
      check("busy_len", (busy_q.size() == 1) ? busy_q[0] : -1, 68);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int ab0;
      bit hit;
      logic [7:0] ra, rb;

      vecs[0] = '{8'h76, 8'hA5, 8'h1B};
      vecs[1] = '{8'h01, 8'h02, 8'h03};
      vecs[2] = '{8'hFF, 8'h01, 8'h00};
      vecs[3] = '{8'h80, 8'h80, 8'h00};
      vecs[4] = '{8'h5A, 8'hC3, 8'h1D};
      vecs[5] = '{8'h0F, 8'hF0, 8'hFF};

      bus.serialClock = 1'b0;
      bus.serialData  = 1'b0;
      reset = 1'b1;
      tick(3);
      check("rst_word", bus.word, 0);
      check("rst_index", bus.index, 0);
      check("rst_wordValid", bus.wordValid, 0);
      check("rst_frameReady", bus.frameReady, 0);
      check("rst_abort", bus.abort, 0);
      check("rst_replyClock", bus.replyClock, 0);
      check("rst_replyData", bus.replyData, 0);
      check("rst_busy", bus.busy, 0);
      reset = 1'b0;
      tick(2);

      for (int i = 0; i < 6; i++) run_frame(vecs[i].a, vecs[i].b, vecs[i].sum, 1'b0, 1'b0);

      // partial frame then stall past the timeout
      word_q.delete(); reply_q.delete(); busy_q.delete();
      ab0 = ab_cnt;
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
      tick(100);
      check("abort_pulses", ab_cnt - ab0, 1);
      check("abort_no_word", word_q.size(), 0);
      check("abort_no_reply", busy_q.size(), 0);
      run_frame(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

      // serial edges while the reply is going out
      run_frame(8'h76, 8'hA5, 8'h1B, 1'b0, 1'b1);
      run_frame(8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);

      // reset in the middle of a reply (sum 0xFF keeps replyData high)
      reply_q.delete();
      send_word(8'hAA, 1'b0);
      send_word(8'h55, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         tick(1);
         if (rx_bits == 3) hit = 1'b1;
      end
      check("reach_reply_bit3", 32'(hit), 32'd1);
      reset = 1'b1;
      tick(1);
      check("midreset_replyClock", bus.replyClock, 0);
      check("midreset_replyData", bus.replyData, 0);
      check("midreset_busy", bus.busy, 0);
      reset = 1'b0;
      tick(100);
      check("midreset_no_resume", bus.busy, 0);
      check("midreset_no_reply", reply_q.size(), 0);
      run_frame(8'h10, 8'h20, 8'h30, 1'b0, 1'b0);

      // random frames with data wiggling away from the clock edges
      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_frame(ra, rb, 8'(ra + rb), 1'b1, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
